// File: rtl/regfile_scoreboard_if.sv
// ID-stage register-file bundle: read ports, issue/flush, write-back and scoreboard status.
// The master side is the decode/issue logic; the slave side is the register file.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [NRD*AW-1:0]    rd_addr_i;
  logic [NRD-1:0]       rd_use_i;
  logic [NRD*WIDTH-1:0] rd_data_o;
  logic [NRD-1:0]       rd_busy_o;
  logic                 stall_o;
  logic                 iss_en_i;
  logic [AW-1:0]        iss_addr_i;
  logic                 flush_i;
  logic                 wr_en_i;
  logic [AW-1:0]        wr_addr_i;
  logic [WIDTH-1:0]     wr_data_i;
  logic [AW:0]          busy_cnt_o;

  modport master (
    output rd_addr_i, rd_use_i, iss_en_i, iss_addr_i, flush_i,
           wr_en_i, wr_addr_i, wr_data_i,
    input  rd_data_o, rd_busy_o, stall_o, busy_cnt_o
  );

  modport slave (
    input  rd_addr_i, rd_use_i, iss_en_i, iss_addr_i, flush_i,
           wr_en_i, wr_addr_i, wr_data_i,
    output rd_data_o, rd_busy_o, stall_o, busy_cnt_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// GPR array with write-first bypass and per-register busy scoreboard; flags load-use
// hazards on consumed operands and stalls issue until the pending write-back lands.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int NRD   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  regfile_scoreboard_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      busy_cnt;
  logic [NRD-1:0]   rd_busy;
  logic             stall;
  logic             wr_ok;
  logic             iss_ok;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{AW{1'b0}}, v[i]};
    return c;
  endfunction

  // Combinational read ports: R0 reads zero, a same-cycle write-back wins over the array
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          bypass;
    assign addr   = bus.rd_addr_i[k*AW +: AW];
    assign bypass = bus.wr_en_i && (bus.wr_addr_i == addr);
    assign bus.rd_data_o[k*WIDTH +: WIDTH] = (addr == '0) ? '0 :
                                             bypass        ? bus.wr_data_i : regs[addr];
    assign rd_busy[k] = (addr != '0) && !bypass && busy[addr];
  end

  assign stall         = |(rd_busy & bus.rd_use_i);
  assign bus.rd_busy_o = rd_busy;
  assign bus.stall_o   = stall;
  assign bus.busy_cnt_o = busy_cnt;

  assign wr_ok  = bus.wr_en_i && (bus.wr_addr_i != '0);
  assign iss_ok = bus.iss_en_i && !stall && !bus.flush_i && (bus.iss_addr_i != '0);

  // Issue is applied after write-back so a colliding issue leaves the register busy
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[bus.wr_addr_i]  = 1'b0;
    if (iss_ok) busy_nxt[bus.iss_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end
endmodule
